// File: rtl/nbit_adder_pkg.sv
// Shared constants for the plain wrapping adder block.
// Kept separate so other arithmetic leaves can agree on the default width.
package nbit_adder_pkg;

  localparam int NBIT_DEFAULT_WIDTH = 2;

endpackage

// File: rtl/nbit_adder_if.sv
// Operand / result bundle for nbit_adder.
// The master drives the operands and the slave returns the combinational and registered results.
interface nbit_adder_if #(
  parameter int N = nbit_adder_pkg::NBIT_DEFAULT_WIDTH
);

  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] C;
  logic         Cout;
  logic [N-1:0] C_q;
  logic         Cout_q;
  logic         Ovf_q;

  modport master (
    output A, B,
    input  C, Cout, C_q, Cout_q, Ovf_q
  );

  modport slave (
    input  A, B,
    output C, Cout, C_q, Cout_q, Ovf_q
  );

endinterface

// File: rtl/nbit_adder_full_adder.sv
// One-bit full adder cell that nbit_adder chains into a ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/nbit_adder.sv
// N-bit ripple-carry adder with a combinational sum and a registered sum/carry/overflow copy.
// The registered copy clears asynchronously on rst_n low and captures on each rising edge.
module nbit_adder
  import nbit_adder_pkg::*;
#(
  parameter int N = NBIT_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  nbit_adder_if.slave  bus
);

  logic [N:0]   carry;
  logic [N-1:0] sum;
  logic         ovf;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      full_adder u_fa (
        .a    (bus.A[gi]),
        .b    (bus.B[gi]),
        .cin  (carry[gi]),
        .s    (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // Signed overflow: like-signed operands whose sum flips the sign bit.
  assign ovf = (bus.A[N-1] == bus.B[N-1]) && (sum[N-1] != bus.A[N-1]);

  assign bus.C    = sum;
  assign bus.Cout = carry[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.C_q    <= '0;
      bus.Cout_q <= 1'b0;
      bus.Ovf_q  <= 1'b0;
    end else begin
      bus.C_q    <= sum;
      bus.Cout_q <= carry[N];
      bus.Ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_nbit_adder.sv
// Scoreboard bench for nbit_adder at N=2 and N=8 sharing one clock and reset.
module tb_nbit_adder;

  typedef struct packed {
    logic [7:0] c;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q2[$];
  exp_t q8[$];

  nbit_adder_if #(.N(2)) bus2 ();
  nbit_adder_if #(.N(8)) bus8 ();

  nbit_adder #(.N(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  nbit_adder #(.N(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    bus2.A = a;
    bus2.B = b;
    s = {1'b0, a} + {1'b0, b};
    e.c    = {6'd0, s[1:0]};
    e.cout = s[2];
    e.ovf  = (a[1] == b[1]) && (s[1] != a[1]);
    #1;
    check("n2_c", 64'(bus2.C), 64'(e.c));
    check("n2_cout", 64'(bus2.Cout), 64'(e.cout));
    q2.push_back(e);
    @(posedge clk);
    #1;
    check("n2_sb_nonempty", 64'(q2.size() != 0), 64'd1);
    if (q2.size() != 0) begin
      got = q2.pop_front();
      check("n2_c_q", 64'(bus2.C_q), 64'(got.c));
      check("n2_cout_q", 64'(bus2.Cout_q), 64'(got.cout));
      check("n2_ovf_q", 64'(bus2.Ovf_q), 64'(got.ovf));
    end
    $display("n2 A=%b B=%b C=%b Cout=%b C_q=%b Cout_q=%b Ovf_q=%b",
             a, b, bus2.C, bus2.Cout, bus2.C_q, bus2.Cout_q, bus2.Ovf_q);
  endtask

  task automatic apply8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    bus8.A = a;
    bus8.B = b;
    s = {1'b0, a} + {1'b0, b};
    e.c    = s[7:0];
    e.cout = s[8];
    e.ovf  = (a[7] == b[7]) && (s[7] != a[7]);
    #1;
    check("n8_c", 64'(bus8.C), 64'(e.c));
    check("n8_cout", 64'(bus8.Cout), 64'(e.cout));
    q8.push_back(e);
    @(posedge clk);
    #1;
    check("n8_sb_nonempty", 64'(q8.size() != 0), 64'd1);
    if (q8.size() != 0) begin
      got = q8.pop_front();
      check("n8_c_q", 64'(bus8.C_q), 64'(got.c));
      check("n8_cout_q", 64'(bus8.Cout_q), 64'(got.cout));
      check("n8_ovf_q", 64'(bus8.Ovf_q), 64'(got.ovf));
    end
    $display("n8 A=%h B=%h C=%h Cout=%b C_q=%h Cout_q=%b Ovf_q=%b",
             a, b, bus8.C, bus8.Cout, bus8.C_q, bus8.Cout_q, bus8.Ovf_q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fail_mark;
    rst_n  = 1'b0;
    bus2.A = 2'b10;
    bus2.B = 2'b11;
    bus8.A = 8'h7F;
    bus8.B = 8'h7F;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with combinational outputs still live.
    check("rst_n2_c_q", 64'(bus2.C_q), 64'd0);
    check("rst_n2_cout_q", 64'(bus2.Cout_q), 64'd0);
    check("rst_n2_ovf_q", 64'(bus2.Ovf_q), 64'd0);
    check("rst_n8_c_q", 64'(bus8.C_q), 64'd0);
    check("rst_n8_ovf_q", 64'(bus8.Ovf_q), 64'd0);
    check("rst_n2_c_live", 64'(bus2.C), 64'd1);
    check("rst_n8_c_live", 64'(bus8.C), 64'hFE);
    $display("reset held: n2 C=%b n8 C=%h", bus2.C, bus8.C);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    apply2(2'b01, 2'b10);
    apply2(2'b11, 2'b01);
    apply2(2'b01, 2'b01);
    apply2(2'b10, 2'b10);
    apply8(8'hFF, 8'h01);
    apply8(8'h80, 8'h80);
    apply8(8'h7F, 8'h01);
    apply8(8'h00, 8'h00);

    // Randomised, stopping at the first mismatch
    fail_mark = n_fail;
    for (int i = 0; i < 100; i++) begin
      apply2(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      apply8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if (n_fail != fail_mark) break;
    end

    // Asynchronous reset between edges
    apply2(2'b01, 2'b01);
    apply8(8'h80, 8'h80);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_n2_c_q", 64'(bus2.C_q), 64'd0);
    check("async_n2_ovf_q", 64'(bus2.Ovf_q), 64'd0);
    check("async_n8_c_q", 64'(bus8.C_q), 64'd0);
    check("async_n8_cout_q", 64'(bus8.Cout_q), 64'd0);
    check("async_n8_ovf_q", 64'(bus8.Ovf_q), 64'd0);
    check("async_n2_c_live", 64'(bus2.C), 64'd2);
    check("async_n8_cout_live", 64'(bus8.Cout), 64'd1);
    $display("async reset: n2 C_q=%b n8 C_q=%h Cout_q=%b", bus2.C_q, bus8.C_q, bus8.Cout_q);
    @(posedge clk);
    #1;
    check("rst_hold_n8_cout_q", 64'(bus8.Cout_q), 64'd0);
    check("rst_hold_n2_ovf_q", 64'(bus2.Ovf_q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply2(2'b11, 2'b10);
    apply8(8'hC0, 8'h50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
